game_round_ctrl: RTL and testbench

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/game_round_ctrl.sv | 128 ++++++++++++
 tb/tb_game_round_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: four-digit guessing game round sequencer (draw, entry, score, result)
module game_round_ctrl #(
  parameter int MAX_TRIES = 8,
  parameter int DRAW_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_p,
  input  logic        enter_p,
  input  logic [3:0]  sw,
  input  logic [15:0] rand_in,
  output logic [15:0] secret,
  output logic [15:0] guess,
  output logic [2:0]  digits,
  output logic [2:0]  a_cnt,
  output logic [2:0]  b_cnt,
  output logic        score_valid,
  output logic [3:0]  tries,
  output logic [2:0]  state
);
  localparam int DW = $clog2(DRAW_MAX + 1);
  typedef enum logic [2:0] {IDLE, DRAW, ENTRY, SCORE, RESULT, WIN, LOSE} st_t;
  st_t st, st_n;
  logic [15:0] secret_n, guess_n, rmod;
  logic [2:0] digits_n, a_n, b_n, a_fin;
  logic [3:0] tries_n, tries_inc, k, k_n, sd, gd;
  logic [DW-1:0] dcnt, dcnt_n;
  logic uniq, hit, ha, hb;
  function automatic logic [3:0] mod10(input logic [3:0] n);
    mod10 = (n >= 4'd10) ? n - 4'd10 : n;
  endfunction
  assign rmod = {mod10(rand_in[15:12]), mod10(rand_in[11:8]), mod10(rand_in[7:4]), mod10(rand_in[3:0])};
  assign uniq = rmod[15:12] != rmod[11:8] && rmod[15:12] != rmod[7:4] && rmod[15:12] != rmod[3:0] &&
                rmod[11:8] != rmod[7:4] && rmod[11:8] != rmod[3:0] && rmod[7:4] != rmod[3:0];
  // digit 0 is the leftmost nibble for both secret and guess
  assign sd = 4'(secret >> {~k[3:2], 2'b00});
  assign gd = 4'(guess >> {~k[1:0], 2'b00});
  assign hit = sd == gd;
  assign ha = hit && k[3:2] == k[1:0];
  assign hb = hit && k[3:2] != k[1:0];
  assign a_fin = a_cnt + 3'(ha);
  assign tries_inc = tries + 4'd1;
  assign state = st;
  assign score_valid = st == RESULT || st == WIN || st == LOSE;
  // next-state and datapath next values; each state reacts only to the pulse it accepts
  always_comb begin
    st_n = st;
    secret_n = secret;
    guess_n = guess;
    digits_n = digits;
    a_n = a_cnt;
    b_n = b_cnt;
    tries_n = tries;
    k_n = k;
    dcnt_n = dcnt;
    case (st)
      IDLE, WIN, LOSE: if (start_p) begin
        st_n = DRAW;
        guess_n = '0;
        digits_n = '0;
        tries_n = '0;
        a_n = '0;
        b_n = '0;
        dcnt_n = '0;
      end
      DRAW: if (uniq) begin
        secret_n = rmod;
        st_n = ENTRY;
      end else if (dcnt == DW'(DRAW_MAX - 1)) begin
        secret_n = 16'h1234;
        st_n = ENTRY;
      end else dcnt_n = dcnt + DW'(1);
      ENTRY: if (digits == 3'd4) begin
        st_n = SCORE;
        k_n = '0;
        a_n = '0;
        b_n = '0;
      end else if (enter_p) begin
        guess_n = {guess[11:0], sw >= 4'd10 ? 4'd9 : sw};
        digits_n = digits + 3'd1;
      end
      SCORE: begin
        a_n = a_fin;
        b_n = b_cnt + 3'(hb);
        k_n = k + 4'd1;
        if (k == 4'd15) begin
          tries_n = tries_inc;
          if (a_fin == 3'd4) st_n = WIN;
          else if (tries_inc == 4'(MAX_TRIES)) st_n = LOSE;
          else st_n = RESULT;
        end
      end
      RESULT: if (enter_p) begin
        st_n = ENTRY;
        guess_n = '0;
        digits_n = '0;
        a_n = '0;
        b_n = '0;
      end
      default: st_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  // datapath registers; reset discards any partial round
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      secret <= '0;
      guess <= '0;
      digits <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
      tries <= '0;
      k <= '0;
      dcnt <= '0;
    end else begin
      secret <= secret_n;
      guess <= guess_n;
      digits <= digits_n;
      a_cnt <= a_n;
      b_cnt <= b_n;
      tries <= tries_n;
      k <= k_n;
      dcnt <= dcnt_n;
    end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: scoreboard bench checking every state/digit-count change of game_round_ctrl
module tb_game_round_ctrl;
  localparam int MAX_TRIES = 2;
  localparam int DRAW_MAX = 64;
  localparam logic [2:0] S_IDLE = 3'd0, S_DRAW = 3'd1, S_ENTRY = 3'd2, S_SCORE = 3'd3,
                         S_RESULT = 3'd4, S_WIN = 3'd5, S_LOSE = 3'd6;
  logic clk = 0, rst, start_p, enter_p, score_valid;
  logic [3:0] sw, tries;
  logic [15:0] rand_in, secret, guess;
  logic [2:0] digits, a_cnt, b_cnt, state;
  typedef struct packed {
    logic [2:0] st;
    logic [15:0] sec;
    logic [15:0] g;
    logic [2:0] dg;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] t;
    logic sv;
  } rec_t;
  rec_t q[$];
  int checks = 0, fails = 0;
  logic mon_en = 0;
  logic [15:0] e_sec, e_g;
  logic [2:0] e_dg, e_a, e_b;
  logic [3:0] e_t;
  game_round_ctrl #(.MAX_TRIES(MAX_TRIES), .DRAW_MAX(DRAW_MAX)) dut (
    .clk(clk), .rst(rst), .start_p(start_p), .enter_p(enter_p), .sw(sw), .rand_in(rand_in),
    .secret(secret), .guess(guess), .digits(digits), .a_cnt(a_cnt), .b_cnt(b_cnt),
    .score_valid(score_valid), .tries(tries), .state(state)
  );
  always #5 clk = ~clk;
  task automatic push_cur(input logic [2:0] s, input logic sv);
    q.push_back({s, e_sec, e_g, e_dg, e_a, e_b, e_t, sv});
  endtask
  task automatic pulse(input logic s, input logic e, input logic [3:0] d);
    @(negedge clk);
    start_p = s;
    enter_p = e;
    sw = d;
    @(negedge clk);
    start_p = 0;
    enter_p = 0;
  endtask
  task automatic enter_digit(input logic s, input logic [3:0] d);
    e_g = {e_g[11:0], d >= 4'd10 ? 4'd9 : d};
    e_dg = e_dg + 3'd1;
    push_cur(S_ENTRY, 0);
    pulse(s, 1, d);
  endtask
  task automatic wait_st(input logic [2:0] s, input int max, input string nm);
    int n = 0;
    while (state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      fails++;
      $display("FAIL %s timeout: state=%0d want=%0d", nm, state, s);
    end
  endtask
  task automatic start_round(input logic [15:0] r, input logic [15:0] sec, input int exp_n);
    int n = 0;
    rand_in = r;
    e_g = 0; e_dg = 0; e_a = 0; e_b = 0; e_t = 0;
    push_cur(S_DRAW, 0);
    e_sec = sec;
    push_cur(S_ENTRY, 0);
    pulse(1, 0, 0);
    while (state !== S_ENTRY && n < DRAW_MAX + 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != exp_n) begin
      fails++;
      $display("FAIL draw_cycles rand=%h: got %0d cycles, want %0d", r, n, exp_n);
    end
  endtask
  task automatic guess4(input logic [15:0] sws, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] fin, input logic s0);
    for (int i = 0; i < 4; i++) enter_digit(i == 0 ? s0 : 1'b0, sws[15-4*i -: 4]);
    push_cur(S_SCORE, 0);
    e_a = a; e_b = b; e_t = e_t + 4'd1;
    push_cur(fin, 1);
    wait_st(fin, 40, "score_done");
  endtask
  task automatic next_guess();
    e_g = 0; e_dg = 0; e_a = 0; e_b = 0;
    push_cur(S_ENTRY, 0);
    pulse(0, 1, 0);
  endtask
  // monitor: every change of state or digit count must match the next queued expectation
  initial begin
    logic [5:0] prev;
    rec_t cur, ex;
    wait (mon_en);
    prev = {state, digits};
    forever begin
      @(negedge clk);
      if ({state, digits} !== prev) begin
        prev = {state, digits};
        cur = {state, secret, guess, digits, a_cnt, b_cnt, tries, score_valid};
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got st=%0d sec=%h g=%h dg=%0d a=%0d b=%0d t=%0d sv=%0d",
                   cur.st, cur.sec, cur.g, cur.dg, cur.a, cur.b, cur.t, cur.sv);
        end else begin
          ex = q.pop_front();
          if (cur !== ex) begin
            fails++;
            $display("FAIL event: got st=%0d sec=%h g=%h dg=%0d a=%0d b=%0d t=%0d sv=%0d, want st=%0d sec=%h g=%h dg=%0d a=%0d b=%0d t=%0d sv=%0d",
                     cur.st, cur.sec, cur.g, cur.dg, cur.a, cur.b, cur.t, cur.sv,
                     ex.st, ex.sec, ex.g, ex.dg, ex.a, ex.b, ex.t, ex.sv);
          end
        end
      end
    end
  end
  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  // directed stimulus
  initial begin
    rst = 1; start_p = 0; enter_p = 0; sw = 0; rand_in = 16'h4C91;
    e_sec = 0; e_g = 0; e_dg = 0; e_a = 0; e_b = 0; e_t = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, secret, guess, digits, a_cnt, b_cnt, tries, score_valid} !== 49'd0) begin
      fails++;
      $display("FAIL reset_state: got st=%0d sec=%h g=%h dg=%0d a=%0d b=%0d t=%0d sv=%0d, want all 0",
               state, secret, guess, digits, a_cnt, b_cnt, tries, score_valid);
    end
    rst = 0;
    mon_en = 1;
    pulse(0, 1, 3);
    start_round(16'h4C91, 16'h4291, 1);
    guess4(16'h0000, 0, 0, S_RESULT, 1);
    pulse(1, 0, 0);
    next_guess();
    guess4(16'h0000, 0, 0, S_LOSE, 0);
    pulse(0, 1, 5);
    start_round(16'h1111, 16'h1234, DRAW_MAX);
    guess4(16'h432F, 0, 3, S_RESULT, 0);
    next_guess();
    guess4(16'h1329, 1, 2, S_LOSE, 0);
    start_round(16'h5678, 16'h5678, 1);
    guess4(16'h5678, 4, 0, S_WIN, 0);
    pulse(0, 1, 1);
    start_round(16'hFA3B, 16'h5031, 1);
    enter_digit(0, 4'd1);
    enter_digit(0, 4'd3);
    enter_digit(0, 4'd0);
    enter_digit(0, 4'd5);
    push_cur(S_SCORE, 0);
    wait_st(S_SCORE, 5, "score_entry");
    repeat (7) @(negedge clk);
    e_sec = 0; e_g = 0; e_dg = 0; e_a = 0; e_b = 0; e_t = 0;
    push_cur(S_IDLE, 0);
    #2 rst = 1;
    @(negedge clk);
    rst = 0;
    pulse(0, 1, 2);
    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d unmatched, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
